// File: rtl/stream_demux_n.sv
// stream_demux_n: packet-aware 1-to-NUM_OUT stream demultiplexer.
//
// A shared source stream is steered to one of NUM_OUT consumers. Each consumer has its
// own small FIFO, so the consumers drain independently. The destination and the enable
// are sampled on the first beat of a packet and held until its last beat. Packets that
// are disabled or that select a channel that does not exist are accepted and discarded.
// Discarded beats are counted in a saturating counter.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous, active-high reset (flushes FIFOs, returns FSM to idle)
//   enable     : routing enable, sampled on the first beat of a packet
//   in_data    : input payload
//   in_sel     : destination channel, sampled on the first beat of a packet
//   in_valid   : input beat valid
//   in_last    : final beat of packet
//   in_ready   : input beat is accepted when in_valid & in_ready
//   out_data   : channel k payload at [k*DATA_W +: DATA_W], zero while that FIFO is empty
//   out_last   : per-channel last flag, zero while that FIFO is empty
//   out_valid  : per-channel FIFO non-empty
//   out_ready  : per-channel consumer ready
//   drop_count : number of discarded beats, saturating
module stream_demux_n #(
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned NUM_OUT    = 4,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_last,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [CNT_W-1:0]          drop_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SEL_N  = 1 << SEL_W;

    typedef enum logic [1:0] {StIdle, StRoute, StDrop} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   lock_sel_q, lock_sel_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic [PTR_W-1:0]   wr_ptr_q [NUM_OUT];
    logic [PTR_W-1:0]   wr_ptr_d [NUM_OUT];
    logic [PTR_W-1:0]   rd_ptr_q [NUM_OUT];
    logic [PTR_W-1:0]   rd_ptr_d [NUM_OUT];
    logic [FCNT_W-1:0]  fcnt_q   [NUM_OUT];
    logic [FCNT_W-1:0]  fcnt_d   [NUM_OUT];
    // Each entry holds {last, data}.
    logic [DATA_W:0]    mem_q    [NUM_OUT][FIFO_DEPTH];
    logic [DATA_W:0]    mem_d    [NUM_OUT][FIFO_DEPTH];

    logic [NUM_OUT-1:0] full;
    logic [NUM_OUT-1:0] nonempty;
    // Full flags padded to every encodable select value so in_sel can index safely.
    logic [SEL_N-1:0]   full_sel;
    logic               sel_in_range;
    logic               route;
    logic [SEL_W-1:0]   dest;
    logic               ready_raw;
    logic               accept;

    // FIFO status and output presentation.
    always_comb begin
        full     = '0;
        nonempty = '0;
        out_data = '0;
        out_last = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            full[k]     = (fcnt_q[k] == FCNT_W'(FIFO_DEPTH));
            nonempty[k] = (fcnt_q[k] != '0);
            if (nonempty[k]) begin
                out_data[k*DATA_W +: DATA_W] = mem_q[k][rd_ptr_q[k]][DATA_W-1:0];
                out_last[k]                  = mem_q[k][rd_ptr_q[k]][DATA_W];
            end
        end
    end

    assign out_valid  = nonempty;
    assign drop_count = drop_cnt_q;

    // Control FSM: routing decision, input handshake, next state and drop counter.
    always_comb begin
        state_d      = state_q;
        lock_sel_d   = lock_sel_q;
        drop_cnt_d   = drop_cnt_q;
        route        = 1'b0;
        dest         = lock_sel_q;
        ready_raw    = 1'b0;
        full_sel     = '0;
        full_sel[NUM_OUT-1:0] = full;
        sel_in_range = ({1'b0, in_sel} < (SEL_W+1)'(NUM_OUT));

        unique case (state_q)
            StIdle: begin
                route     = enable && sel_in_range;
                dest      = in_sel;
                ready_raw = route ? !full_sel[in_sel] : 1'b1;
            end
            StRoute: begin
                route     = 1'b1;
                ready_raw = !full_sel[lock_sel_q];
            end
            StDrop: begin
                ready_raw = 1'b1;
            end
            default: begin
                ready_raw = 1'b0;
            end
        endcase

        // Nothing is accepted while reset is asserted.
        in_ready = ready_raw && !reset;
        accept   = in_valid && in_ready;

        unique case (state_q)
            StIdle: begin
                if (accept && !in_last) begin
                    state_d    = route ? StRoute : StDrop;
                    lock_sel_d = in_sel;
                end
            end
            StRoute, StDrop: begin
                if (accept && in_last) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept && !route && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Per-channel FIFO next state; push and pop are independent per channel.
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            logic push;
            logic pop;
            wr_ptr_d[k] = wr_ptr_q[k];
            rd_ptr_d[k] = rd_ptr_q[k];
            fcnt_d[k]   = fcnt_q[k];
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                mem_d[k][e] = mem_q[k][e];
            end
            push = accept && route && (dest == SEL_W'(k));
            pop  = nonempty[k] && out_ready[k];
            if (push) begin
                mem_d[k][wr_ptr_q[k]] = {in_last, in_data};
                wr_ptr_d[k]           = wr_ptr_q[k] + 1'b1;
            end
            if (pop) begin
                rd_ptr_d[k] = rd_ptr_q[k] + 1'b1;
            end
            if (push && !pop) begin
                fcnt_d[k] = fcnt_q[k] + 1'b1;
            end else if (!push && pop) begin
                fcnt_d[k] = fcnt_q[k] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            lock_sel_q <= '0;
            drop_cnt_q <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                fcnt_q[k]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            drop_cnt_q <= drop_cnt_d;
            for (int k = 0; k < NUM_OUT; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                fcnt_q[k]   <= fcnt_d[k];
            end
        end
        // Storage needs no reset: entries are only visible through a non-zero count.
        for (int k = 0; k < NUM_OUT; k++) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                mem_q[k][e] <= mem_d[k][e];
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n: directed packets, with expected beats queued per channel on
// acceptance and popped by an independent monitor whenever a channel hands a beat over.
module tb_stream_demux_n;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] out_data;
    logic [3:0]  out_last;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [7:0]  drop_count;

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_q [4][$];

    stream_demux_n #(
        .DATA_W     (4),
        .NUM_OUT    (4),
        .SEL_W      (2),
        .FIFO_DEPTH (2),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    // exp_ch < 0 means the beat is expected to be dropped.
    task automatic send_beat(input logic [3:0] d, input logic [1:0] s, input logic l,
                             input logic en, input int exp_ch, output int waits);
        in_data  = d;
        in_sel   = s;
        in_last  = l;
        enable   = en;
        in_valid = 1'b1;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 20) begin
                total++;
                bad++;
                $display("FAIL accept_timeout got=in_ready_low required=accept data=%0h", d);
                @(posedge clk);
                #1 in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        if (exp_ch >= 0) exp_q[exp_ch].push_back({l, d});
        #1 in_valid = 1'b0;
    endtask

    // Scoreboard monitor: every handed-over beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    logic [4:0] got;
                    logic [4:0] want;
                    got = {out_last[k], out_data[k*4 +: 4]};
                    total++;
                    if (exp_q[k].size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_beat ch%0d got=%0h required=none", k, got);
                    end else begin
                        want = exp_q[k].pop_front();
                        if (got !== want) begin
                            bad++;
                            $display("FAIL beat_ch%0d got=%0h required=%0h", k, got, want);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset     = 1'b1;
        enable    = 1'b1;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 4'hF;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", in_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // 1: single-beat routing to ch2.
        send_beat(4'hA, 2'd2, 1'b1, 1'b1, 2, w);
        @(negedge clk);
        check("t1_valid", out_valid, 4'b0100);
        check("t1_data", out_data[11:8], 4'hA);
        check("t1_last", out_last, 4'b0100);
        @(negedge clk);
        check("t1_valid_after", out_valid, 0);
        @(posedge clk);
        #1;

        // 2: select locked on first beat.
        send_beat(4'h1, 2'd1, 1'b0, 1'b1, 1, w);
        send_beat(4'h2, 2'd3, 1'b0, 1'b1, 1, w);
        send_beat(4'h3, 2'd3, 1'b1, 1'b1, 1, w);
        repeat (3) @(posedge clk);
        #1;
        check("t2_ch1_drained", exp_q[1].size(), 0);

        // 3: backpressure on ch0.
        out_ready = 4'b1110;
        send_beat(4'h1, 2'd0, 1'b0, 1'b1, 0, w);
        send_beat(4'h2, 2'd0, 1'b0, 1'b1, 0, w);
        in_data  = 4'h3;
        in_last  = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("t3_ready_low", in_ready, 0);
        check("t3_valid_full", out_valid, 4'b0001);
        @(posedge clk);
        @(negedge clk);
        check("t3_ready_hold", in_ready, 0);
        @(posedge clk);
        #1 out_ready = 4'hF;
        send_beat(4'h3, 2'd0, 1'b1, 1'b1, 0, w);
        check("t3_waited", (w > 0), 1);
        repeat (3) @(posedge clk);
        #1;
        check("t3_ch0_drained", exp_q[0].size(), 0);

        // 4: disabled packet, then saturation.
        for (int i = 0; i < 4; i++) begin
            send_beat(4'(i + 4), 2'd1, (i == 3), 1'b0, -1, w);
            check("t4_ready_high", w, 0);
        end
        @(negedge clk);
        check("t4_drop4", drop_count, 4);
        check("t4_no_valid", out_valid, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 251; i++) send_beat(4'hE, 2'd0, 1'b1, 1'b0, -1, w);
        @(negedge clk);
        check("t4_drop255", drop_count, 255);
        @(posedge clk);
        #1;
        for (int i = 0; i < 49; i++) send_beat(4'hE, 2'd0, 1'b1, 1'b0, -1, w);
        @(negedge clk);
        check("t4_drop_sat", drop_count, 255);
        @(posedge clk);
        #1;

        // 5: ch0 pops while ch3 pushes in the same cycle.
        out_ready = 4'b1110;
        send_beat(4'h6, 2'd0, 1'b1, 1'b1, 0, w);
        send_beat(4'h7, 2'd0, 1'b1, 1'b1, 0, w);
        out_ready = 4'b1001;
        send_beat(4'h9, 2'd3, 1'b1, 1'b1, 3, w);
        @(negedge clk);
        check("t5_valid_both", out_valid, 4'b1001);
        check("t5_ch3_data", out_data[15:12], 4'h9);
        @(negedge clk);
        check("t5_valid_after", out_valid, 0);
        @(posedge clk);
        #1;

        // 6: reset in the middle of a packet to ch2.
        out_ready = 4'b1011;
        send_beat(4'hB, 2'd2, 1'b0, 1'b1, 2, w);
        send_beat(4'hC, 2'd2, 1'b0, 1'b1, 2, w);
        reset = 1'b1;
        @(negedge clk);
        check("t6_ready_in_reset", in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q[2].delete();
        out_ready = 4'hF;
        @(negedge clk);
        check("t6_valid_flushed", out_valid, 0);
        check("t6_drop_cleared", drop_count, 0);
        @(posedge clk);
        #1;
        send_beat(4'h5, 2'd0, 1'b1, 1'b1, 0, w);
        @(negedge clk);
        check("t6_routes_ch0", out_valid, 4'b0001);
        repeat (3) @(posedge clk);
        #1;

        for (int k = 0; k < 4; k++) check($sformatf("final_empty_ch%0d", k), exp_q[k].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
